// File: rtl/router_tx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : router_tx_pkg
//  Description : Shared types and constants for the router packet transmitter:
//                FSM state encoding, reject codes and header byte ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_tx_pkg;

    // Transmitter FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_e;

    // Reject codes, identical to the values the router itself reports
    localparam logic [3:0] ERR_NONE = 4'd0;
    localparam logic [3:0] ERR_MIN  = 4'd3;
    localparam logic [3:0] ERR_MAX  = 4'd4;
    localparam logic [3:0] ERR_LEN  = 4'd5;

    // Number of framing bytes in front of the payload
    localparam int HDR_BYTES = 4;

    // Position of each field inside the header
    typedef enum logic [1:0] {
        HB_SA  = 2'd0,
        HB_DA  = 2'd1,
        HB_LEN = 2'd2,
        HB_CRC = 2'd3
    } hdr_byte_e;

    // Select the header byte that goes out at a given header position
    function automatic logic [7:0] hdr_byte(
        input logic [1:0] idx,
        input logic [7:0] sa,
        input logic [7:0] da,
        input logic [7:0] len,
        input logic [7:0] crc
    );
        logic [7:0] b;
        case (hdr_byte_e'(idx))
            HB_SA:   b = sa;
            HB_DA:   b = da;
            HB_LEN:  b = len;
            default: b = crc;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : router_tx_fifo
//  Description : Synchronous 8-bit payload FIFO with flush and occupancy count.
//                Read data is the current head (show-ahead), so a pop and the
//                use of the popped byte happen in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_tx_fifo
    import router_tx_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH) + 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [7:0]       i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [7:0]       o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [7:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                w_push_ok;
    logic                w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage array; a write during a flush is harmless since the pointers reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush has priority over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : router_pkt_tx
//  Description : Frames payload bytes from an internal FIFO into a router
//                packet (SA, DA, LEN, CRC, payload) and streams it one byte per
//                cycle once the router is not busy. Illegal requests are
//                rejected locally with the router's own error codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx
    import router_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int MIN_PKT    = 12,
    parameter int MAX_PKT    = 255,
    parameter int GAP        = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       start,
    input  logic [7:0] sa,
    input  logic [7:0] da,
    input  logic [7:0] pay_len,
    input  logic       busy,
    output logic [7:0] dut_inp,
    output logic       inp_valid,
    output logic       tx_active,
    output logic       done,
    output logic [3:0] error
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    // Registered state
    tx_state_e  r_state;
    logic [7:0] r_sa;
    logic [7:0] r_da;
    logic [7:0] r_len;
    logic [7:0] r_crc_hdr;
    logic [7:0] r_crc;
    logic [7:0] r_pay_len;
    logic [1:0] r_idx;
    logic [7:0] r_pay_cnt;
    logic [7:0] r_gap_cnt;
    logic [7:0] r_dout;
    logic       r_valid;
    logic       r_done;
    logic [3:0] r_error;

    // Next-state values
    tx_state_e  w_state_nxt;
    logic [7:0] w_sa_nxt;
    logic [7:0] w_da_nxt;
    logic [7:0] w_len_nxt;
    logic [7:0] w_crc_hdr_nxt;
    logic [7:0] w_crc_nxt;
    logic [7:0] w_pay_len_nxt;
    logic [1:0] w_idx_nxt;
    logic [7:0] w_pay_cnt_nxt;
    logic [7:0] w_gap_cnt_nxt;
    logic [7:0] w_dout_nxt;
    logic       w_valid_nxt;
    logic       w_done_nxt;
    logic [3:0] w_error_nxt;

    // FIFO interface
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [7:0]         w_fifo_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic [c_cnt_w-1:0] w_count_eff;
    logic [8:0]         w_len9;
    logic [1:0]         w_idx_inc;

    assign wr_ready  = (r_state == ST_IDLE) && !w_fifo_full;
    assign w_push    = wr_valid && wr_ready;
    assign tx_active = (r_state != ST_IDLE);
    assign dut_inp   = r_dout;
    assign inp_valid = r_valid;
    assign done      = r_done;
    assign error     = r_error;

    // A same-cycle write counts toward the start check
    assign w_count_eff = w_fifo_count + c_cnt_w'(w_push);
    // 9-bit total length so pay_len+4 cannot wrap
    assign w_len9      = {1'b0, pay_len} + 9'd4;
    assign w_idx_inc   = r_idx + 2'd1;

    router_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // State and output registers; outputs are registered from next-state values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sa      <= '0;
            r_da      <= '0;
            r_len     <= '0;
            r_crc_hdr <= '0;
            r_crc     <= '0;
            r_pay_len <= '0;
            r_idx     <= '0;
            r_pay_cnt <= '0;
            r_gap_cnt <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= ERR_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_sa      <= w_sa_nxt;
            r_da      <= w_da_nxt;
            r_len     <= w_len_nxt;
            r_crc_hdr <= w_crc_hdr_nxt;
            r_crc     <= w_crc_nxt;
            r_pay_len <= w_pay_len_nxt;
            r_idx     <= w_idx_nxt;
            r_pay_cnt <= w_pay_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_dout    <= w_dout_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    // Next-state, start checks and next output byte
    always_comb begin
        w_state_nxt   = r_state;
        w_sa_nxt      = r_sa;
        w_da_nxt      = r_da;
        w_len_nxt     = r_len;
        w_crc_hdr_nxt = r_crc_hdr;
        w_crc_nxt     = r_crc ^ (w_push ? wr_data : 8'h00);
        w_pay_len_nxt = r_pay_len;
        w_idx_nxt     = r_idx;
        w_pay_cnt_nxt = r_pay_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_dout_nxt    = 8'h00;
        w_valid_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_error_nxt   = r_error;
        w_pop         = 1'b0;
        w_flush       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_len9 < 9'(MIN_PKT)) begin
                        w_error_nxt = ERR_MIN;
                        w_flush     = 1'b1;
                        w_crc_nxt   = 8'h00;
                    end else if (w_len9 > 9'(MAX_PKT)) begin
                        w_error_nxt = ERR_MAX;
                        w_flush     = 1'b1;
                        w_crc_nxt   = 8'h00;
                    end else if (w_count_eff != c_cnt_w'(pay_len)) begin
                        w_error_nxt = ERR_LEN;
                        w_flush     = 1'b1;
                        w_crc_nxt   = 8'h00;
                    end else begin
                        w_sa_nxt      = sa;
                        w_da_nxt      = da;
                        w_len_nxt     = w_len9[7:0];
                        w_crc_hdr_nxt = w_crc_nxt;
                        w_pay_len_nxt = pay_len;
                        w_error_nxt   = ERR_NONE;
                        w_state_nxt   = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!busy) begin
                    w_state_nxt = ST_HDR;
                    w_idx_nxt   = 2'd0;
                    w_dout_nxt  = hdr_byte(2'd0, r_sa, r_da, r_len, r_crc_hdr);
                    w_valid_nxt = 1'b1;
                end
            end

            ST_HDR: begin
                w_valid_nxt = 1'b1;
                if (r_idx == 2'(HDR_BYTES - 1)) begin
                    w_pop         = !w_fifo_empty;
                    w_dout_nxt    = w_fifo_data;
                    w_pay_cnt_nxt = 8'd1;
                    w_state_nxt   = ST_PAY;
                end else begin
                    w_idx_nxt  = w_idx_inc;
                    w_dout_nxt = hdr_byte(w_idx_inc, r_sa, r_da, r_len, r_crc_hdr);
                end
            end

            ST_PAY: begin
                if (r_pay_cnt == r_pay_len) begin
                    w_done_nxt    = 1'b1;
                    w_gap_cnt_nxt = 8'd1;
                    w_state_nxt   = ST_GAP;
                end else begin
                    w_pop         = !w_fifo_empty;
                    w_dout_nxt    = w_fifo_data;
                    w_valid_nxt   = 1'b1;
                    w_pay_cnt_nxt = r_pay_cnt + 8'd1;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == 8'(GAP)) begin
                    w_state_nxt = ST_IDLE;
                    w_crc_nxt   = 8'h00;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_router_pkt_tx
//  Description : Self-checking bench for router_pkt_tx. Table-driven directed
//                packets, randomized packets against a byte-stream model, and
//                a reset-mid-payload sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;
    import router_tx_pkg::*;

    localparam int MIN_PKT = 12;
    localparam int MAX_PKT = 255;
    localparam int GAP     = 2;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       start;
    logic [7:0] sa;
    logic [7:0] da;
    logic [7:0] pay_len;
    logic       busy;
    logic [7:0] dut_inp;
    logic       inp_valid;
    logic       tx_active;
    logic       done;
    logic [3:0] error;

    int n_checks;
    int n_fail;

    router_pkt_tx #(
        .FIFO_DEPTH (256),
        .MIN_PKT    (MIN_PKT),
        .MAX_PKT    (MAX_PKT),
        .GAP        (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .start     (start),
        .sa        (sa),
        .da        (da),
        .pay_len   (pay_len),
        .busy      (busy),
        .dut_inp   (dut_inp),
        .inp_valid (inp_valid),
        .tx_active (tx_active),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decision from the packet-size and count rules
    function automatic logic [3:0] model_err(input int plen, input int cnt);
        if (plen + 4 < MIN_PKT) return ERR_MIN;
        if (plen + 4 > MAX_PKT) return ERR_MAX;
        if (cnt != plen)        return ERR_LEN;
        return ERR_NONE;
    endfunction

    // Write nwr bytes, request a packet of plen bytes, then follow it to the end.
    // abort_at >= 0 pulls reset while that stream byte is on the bus.
    task automatic run_packet(
        input logic [7:0] t_sa,
        input logic [7:0] t_da,
        input int         plen,
        input int         nwr,
        input int         busy_cyc,
        input bit         with_last,
        input bit         fixed_data,
        input logic [3:0] exp_err,
        input int         abort_at
    );
        logic [7:0] exp_q[$];
        logic [7:0] crc;
        logic [7:0] d;
        int         n_valid;
        int         lat;
        int         gap_cnt;
        bit         all_ready;
        bit         bad;
        bit         busy_ready;
        bit         done_extra;
        bit         same_cycle;

        crc        = 8'h00;
        all_ready  = 1'b1;
        exp_q      = {};
        same_cycle = with_last && (nwr > 0);
        busy       = (busy_cyc > 0);

        for (int i = 0; i < nwr; i++) begin
            d = fixed_data ? 8'(8'h11 + i) : 8'($urandom);
            exp_q.push_back(d);
            crc ^= d;
            if (!wr_ready) all_ready = 1'b0;
            wr_valid = 1'b1;
            wr_data  = d;
            if (same_cycle && i == nwr - 1) begin
                start   = 1'b1;
                sa      = t_sa;
                da      = t_da;
                pay_len = 8'(plen);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (nwr > 0) check("wr_ready_idle", 32'(all_ready), 32'd1);

        if (!same_cycle) begin
            start   = 1'b1;
            sa      = t_sa;
            da      = t_da;
            pay_len = 8'(plen);
            @(negedge clk);
        end
        start   = 1'b0;
        pay_len = 8'($urandom);
        sa      = 8'($urandom);
        da      = 8'($urandom);

        check("error_code", 32'(error), 32'(exp_err));

        if (exp_err != ERR_NONE) begin
            check("reject_idle", 32'(tx_active), 32'd0);
            check("reject_wr_ready", 32'(wr_ready), 32'd1);
            bad = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (inp_valid || tx_active) bad = 1'b1;
            end
            check("reject_no_tx", 32'(bad), 32'd0);
            check("reject_err_held", 32'(error), 32'(exp_err));
            busy = 1'b0;
            return;
        end

        check("accept_active", 32'(tx_active), 32'd1);
        exp_q.push_front(crc);
        exp_q.push_front(8'(plen + 4));
        exp_q.push_front(t_da);
        exp_q.push_front(t_sa);

        // Held busy keeps the block waiting with nothing on the bus
        bad = (inp_valid || dut_inp != 8'h00);
        for (int b = 1; b <= busy_cyc; b++) begin
            @(negedge clk);
            if (inp_valid || !tx_active || dut_inp != 8'h00) bad = 1'b1;
        end
        busy = 1'b0;
        check("wait_while_busy", 32'(bad), 32'd0);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!inp_valid && lat < 20);
        check("first_byte_latency", 32'(lat), 32'd1);

        // Stream capture; busy toggles and a stray start must not disturb it
        n_valid    = 0;
        busy_ready = 1'b0;
        while (inp_valid && n_valid < 300) begin
            if (n_valid < exp_q.size())
                check($sformatf("byte%0d", n_valid), 32'(dut_inp), 32'(exp_q[n_valid]));
            if (wr_ready) busy_ready = 1'b1;
            if (n_valid == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_inp_valid", 32'(inp_valid), 32'd0);
                check("rst_dut_inp", 32'(dut_inp), 32'd0);
                check("rst_tx_active", 32'(tx_active), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_error", 32'(error), 32'd0);
                check("rst_wr_ready", 32'(wr_ready), 32'd1);
                busy  = 1'b0;
                start = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            n_valid++;
            busy    = 1'($urandom);
            start   = (n_valid == 2);
            pay_len = (n_valid == 2) ? 8'd3 : 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        busy  = 1'b0;

        check("valid_len", 32'(n_valid), 32'(exp_q.size()));
        check("wr_ready_during_pkt", 32'(busy_ready), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("idle_bus_zero", 32'(dut_inp), 32'd0);

        // Count post-packet cycles that are still active with the bus idle
        gap_cnt    = 0;
        bad        = 1'b0;
        done_extra = 1'b0;
        while (tx_active && gap_cnt < 10) begin
            if (inp_valid || dut_inp != 8'h00) bad = 1'b1;
            if (gap_cnt > 0 && done) done_extra = 1'b1;
            gap_cnt++;
            @(negedge clk);
        end
        check("gap_cycles", 32'(gap_cnt), 32'(GAP));
        check("gap_bus_idle", 32'(bad), 32'd0);
        check("done_single", 32'(done_extra | done), 32'd0);
        check("stray_start_ignored", 32'(error), 32'd0);
    endtask

    typedef struct {
        logic [7:0] sa;
        logic [7:0] da;
        int         plen;
        int         nwr;
        int         busy_cyc;
        bit         with_last;
        bit         fixed;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'h01, 8'h02,   8,   8, 0, 1'b0, 1'b1, ERR_NONE}; // nominal
        vecs[1] = '{8'h01, 8'h02,   8,   8, 5, 1'b0, 1'b1, ERR_NONE}; // busy held
        vecs[2] = '{8'h05, 8'h06,  10,   9, 0, 1'b0, 1'b0, ERR_LEN};  // count mismatch
        vecs[3] = '{8'h07, 8'h08,   8,   8, 0, 1'b1, 1'b0, ERR_NONE}; // start on last write, FIFO was flushed
        vecs[4] = '{8'h09, 8'h0A,   4,   4, 0, 1'b0, 1'b0, ERR_MIN};
        vecs[5] = '{8'h0B, 8'h0C,   7,   7, 0, 1'b0, 1'b0, ERR_MIN};
        vecs[6] = '{8'h0D, 8'h0E, 252,   0, 0, 1'b0, 1'b0, ERR_MAX};
        vecs[7] = '{8'hA5, 8'h5A, 251, 251, 1, 1'b0, 1'b0, ERR_NONE}; // LEN = 0xFF
        vecs[8] = '{8'h10, 8'h20,   8,   9, 0, 1'b0, 1'b0, ERR_LEN};

        reset    = 1'b0;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        start    = 1'b0;
        sa       = 8'h00;
        da       = 8'h00;
        pay_len  = 8'h00;
        busy     = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_dut_inp", 32'(dut_inp), 32'd0);
        check("reset_inp_valid", 32'(inp_valid), 32'd0);
        check("reset_tx_active", 32'(tx_active), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_packet(vecs[v].sa, vecs[v].da, vecs[v].plen, vecs[v].nwr,
                       vecs[v].busy_cyc, vecs[v].with_last, vecs[v].fixed,
                       vecs[v].exp_err, -1);
        end

        // Back-to-back: second packet requested as early as the write side allows
        run_packet(8'h31, 8'h32, 8, 8, 0, 1'b0, 1'b0, ERR_NONE, -1);
        run_packet(8'h41, 8'h42, 8, 8, 0, 1'b1, 1'b0, ERR_NONE, -1);

        // Reset while the 6th payload byte (stream index 9) is on the bus
        run_packet(8'h51, 8'h52, 8, 8, 0, 1'b0, 1'b0, ERR_NONE, 9);
        run_packet(8'h01, 8'h02, 8, 8, 0, 1'b0, 1'b1, ERR_NONE, -1);

        // Randomized requests against the size/count rules and the stream model
        for (int r = 0; r < 24; r++) begin
            int sel;
            int plen;
            int nwr;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                plen = $urandom_range(0, 7);
                nwr  = plen;
            end else if (sel == 1) begin
                plen = $urandom_range(252, 255);
                nwr  = $urandom_range(0, 3);
            end else if (sel == 2) begin
                plen = $urandom_range(8, 40);
                nwr  = plen + (($urandom_range(0, 1) == 0) ? 1 : -1);
            end else begin
                plen = $urandom_range(8, 40);
                nwr  = plen;
            end
            run_packet(8'($urandom), 8'($urandom), plen, nwr,
                       $urandom_range(0, 3), 1'($urandom), 1'b0,
                       model_err(plen, nwr), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- RTL packet transmitter that feeds the router's input port (dut_inp / inp_valid) and honours its busy output.
- Payload bytes are pushed into an internal FIFO.
- On start, the block frames one packet and streams it one byte per cycle: SA, DA, LEN, CRC, then the payload.
- Illegal requests are rejected locally with the same error codes the router uses, so a bad packet never reaches the router.

Parameters:
- FIFO_DEPTH, 256, payload FIFO entries (power of 2, at least MAX_PKT-4).
- MIN_PKT, 12, minimum total packet length in bytes, header included.
- MAX_PKT, 255, maximum total packet length in bytes; must be 255 or less because LEN is 8 bits.
- GAP, 2, minimum idle cycles with inp_valid low between packets.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_data  in  8  payload byte.
- wr_valid  in  1  payload write request.
- wr_ready  out  1  FIFO can accept a byte.
- start  in  1  single-cycle request to send a packet.
- sa  in  8  source address, sampled on an accepted start.
- da  in  8  destination address, sampled on an accepted start.
- pay_len  in  8  payload byte count, sampled on an accepted start.
- busy  in  1  router busy.
- dut_inp  out  8  byte to router.
- inp_valid  out  1  dut_inp valid.
- tx_active  out  1  packet in progress (any state other than IDLE).
- done  out  1  one-cycle pulse after the last byte is sent.
- error  out  4  reject code, held until the next accepted start.

Behaviour:
- Reset (asynchronous, low): FIFO emptied, running CRC cleared, state IDLE.
  - Outputs at reset: dut_inp=0, inp_valid=0, tx_active=0, done=0, error=0, wr_ready=1.
- Reset asserted mid-packet: inp_valid drops immediately. The partial packet is abandoned and the router reports it.
- Write side:
  - A byte is written when wr_valid && wr_ready.
  - wr_ready = (state==IDLE) && !fifo_full.
  - Each written byte is XORed into a running CRC register (8-bit).
- start outside IDLE is ignored.
- Start checks in IDLE, evaluated in this priority order:
  - (pay_len+4) < MIN_PKT -> error=3.
  - (pay_len+4) > MAX_PKT -> error=4. Compute in 9 bits so the addition cannot overflow.
  - fifo_count != pay_len -> error=5.
  - On any reject: FIFO flushed, CRC cleared, state stays IDLE, nothing driven.
  - Otherwise: latch sa, da, len = pay_len+4 and crc; set error=0; go to WAIT.
- FSM states IDLE, WAIT, HDR, PAY, GAP:
  - WAIT: at each posedge, if busy==0 go to HDR. Otherwise stay; no timeout.
  - HDR: drive SA, DA, LEN, CRC on four consecutive cycles with inp_valid=1, then go to PAY.
  - PAY: pop one FIFO byte per cycle and drive it. After pay_len bytes go to GAP. pay_len is at least 8, so this state is never empty.
  - GAP: inp_valid=0 and dut_inp=0 for exactly GAP cycles. done pulses on the first GAP cycle. Then go to IDLE and clear CRC.
- Latency: start accepted at edge k with busy low -> SA valid in the cycle after edge k+1, i.e. 2 cycles from start to first byte.
- inp_valid is high for exactly len contiguous cycles per packet.
- busy changes after the first byte is driven are ignored; the packet is never paused.
- dut_inp, inp_valid and done are registered outputs. dut_inp is 0 whenever inp_valid is 0.
- wr_valid and start in the same IDLE cycle: the write is counted before the start check. A start that coincides with the final payload write is therefore accepted.

Decomposition:
- Shared package router_tx_pkg holds:
  - the state enum;
  - error code constants: ERR_NONE=0, ERR_MIN=3, ERR_MAX=4, ERR_LEN=5 (same values as the router);
  - HDR_BYTES=4;
  - the header byte order.
- One sub-module, router_tx_fifo:
  - synchronous 8-bit FIFO with push, pop, flush, full, empty and count outputs;
  - asynchronous active-low reset.

Test Plan:
- Nominal packet: write payload 0x11..0x18 (8 bytes), start with sa=0x01, da=0x02, pay_len=8, busy=0.
  - Required: inp_valid high 12 cycles with bytes 01,02,0C,08,11..18.
  - done pulses one cycle after the last byte; error=0.
- Busy held: same packet with busy=1 for 5 cycles after start.
  - Required: state stays WAIT and inp_valid=0; SA appears 1 cycle after busy is sampled low.
- Length mismatch: write 9 bytes, start with pay_len=10.
  - Required: error=5, no inp_valid, fifo_count=0, wr_ready=1.
- Size bounds:
  - pay_len=4 with 4 bytes written -> error=3.
  - pay_len=252 -> error=4.
  - pay_len=251 with 251 bytes written -> packet sent with LEN=0xFF.
- Back-to-back: second start is ignored while not IDLE. A start in the cycle after IDLE is re-entered succeeds.
  - Required: exactly GAP=2 low cycles between the two packets; wr_ready=0 throughout each packet.
- Reset mid-payload: assert reset on the 6th byte.
  - Required: inp_valid=0 asynchronously and all outputs at reset values.
  - After release, a fresh 8-byte packet transmits correctly.
